jedro_1_csr_bank: RTL
=====================

// Module: jedro_1_csr_bank
// PURPOSE
//  Parametrised machine-mode CSR bank for the jedro_1 core.
//  - NUM_SCRATCH scratch registers.
//  - Cycle/instret counters of width CNT_WIDTH.
//  - Full Zicsr op set: CSRRW/RS/RC and the immediate forms.
//  - Illegal-access detection.
//  Sits beside the decoder. Receives one CSR op per cycle; returns the old CSR value one cycle later for regfile writeback.
// PARAMETERS
//  DATA_WIDTH   32  CSR/data width (fixed to 32 in the core)
//  NUM_SCRATCH  4   scratch registers, 1..8; scratch0 at 0x340, scratchK at 0x7C0+K
//  CNT_WIDTH    64  mcycle/minstret width, 33..64; upper-half bits >= CNT_WIDTH read 0
// PORTS
//  clk_i       in   1           clock, rising edge
//  rst_i       in   1           asynchronous reset, active-high
//  valid_i     in   1           CSR op issued this cycle
//  op_i        in   3           funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
//  addr_i      in   12          CSR address
//  rs1_data_i  in   DATA_WIDTH  rs1 operand (register forms)
//  uimm_i      in   5           zero-extended immediate (I forms)
//  rs1_zero_i  in   1           rs1 field is x0 (register RS/RC forms)
//  instret_i   in   1           instruction-retired pulse
//  rdata_o     out  DATA_WIDTH  old CSR value, registered
//  rvalid_o    out  1           rdata_o/illegal_o valid, one-cycle pulse
//  illegal_o   out  1           access illegal, one-cycle pulse
// BEHAVIOUR
//  - Reset: all scratch regs, counters, rdata_o, rvalid_o and illegal_o are 0 while rst_i=1.
//    - Asserting rst_i mid-access discards the pending response immediately.
//  - Latency: op sampled at edge N.
//    - Response at N+1: rvalid_o=1 for exactly one cycle, rdata_o = value before edge N.
//    - Write is committed at edge N.
//  - valid_i may be high every cycle. An op at N+1 sees the value written at N (no hazard).
//  - Operand: uimm_i zero-extended for 1xx ops, rs1_data_i otherwise.
//    - RW: new = operand.
//    - RS: new = old | operand.
//    - RC: new = old & ~operand.
//  - Write suppression (read-only access, never illegal):
//    - RS/RC with rs1_zero_i=1.
//    - RSI/RCI with uimm_i=0.
//    - RW/RWI always write.
//  - Address map:
//    - 0x340 scratch0.
//    - 0x7C1..0x7C0+NUM_SCRATCH-1 scratch1..N-1.
//    - 0xB00/0xB80 mcycle lo/hi and 0xB02/0xB82 minstret lo/hi: RW.
//    - 0xC00/0xC80/0xC02/0xC82 are read-only mirrors of the same counters.
//  - Illegal: any of the following sets illegal_o=1 at N+1 with rvalid_o=1 and rdata_o=0. No state changes.
//    - Unmapped address.
//    - op 000 or 100.
//    - Unsuppressed write to 0xCxx.
//  - Counters:
//    - mcycle +1 every cycle.
//    - minstret +1 on each cycle with instret_i=1.
//    - Both wrap modulo 2^CNT_WIDTH to 0.
//  - Half writes:
//    - Lo write replaces bits [31:0] and keeps the upper bits.
//    - Hi write replaces bits [CNT_WIDTH-1:32]; excess write bits are dropped.
//  - Simultaneous CSR write and increment on the same counter: the write wins, no increment that cycle.
//  - valid_i=0: outputs return to 0 the next cycle; counters keep running.
// TESTING
//  1. Reset; CSRRW 0x340 rs1=3; then CSRRWI 0x340 uimm=6 -> second rdata_o=3, later read of 0x340 = 6.
//  2. scratch1=0x0F; CSRRS 0x7C1 rs1=0xF0 -> rdata_o=0x0F, reg=0xFF; CSRRC rs1_zero_i=1 -> reg stays 0xFF.
//  3. CSRRW 0xB00 rs1=0xFFFF_FFFE at edge N; CSRRS 0xB80 x0 at edge N+3 -> rdata_o=1 (carry into hi).
//  4. CSRRW 0xC02 -> illegal_o=1, rdata_o=0, minstret unchanged; CSRRS 0xC02 x0 -> legal, returns minstret.
//  5. CNT_WIDTH=40: mcycle=2^40-1, one cycle later = 0; write 0xB80=0xFFFF_FFFF -> reads 0x0000_00FF.
//  6. rst_i asserted the cycle after valid_i -> rvalid_o=0 immediately, all CSRs read 0 after release.

Source files
------------

// File: rtl/jedro_1_csr_bank.sv
// Machine-mode CSR bank for jedro_1: scratch registers, mcycle/minstret counters and
// the Zicsr read-modify-write ops, with a registered old-value response one cycle after issue.
module jedro_1_csr_bank #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SCRATCH = 4,
  parameter int CNT_WIDTH   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [2:0]            op_i,
  input  logic [11:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [4:0]            uimm_i,
  input  logic                  rs1_zero_i,
  input  logic                  instret_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  illegal_o
);

  localparam int IDX_W     = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;
  localparam int SCR_DEPTH = 1 << IDX_W;
  localparam int HI_W      = CNT_WIDTH - 32;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [DATA_WIDTH-1:0] scratch_q [SCR_DEPTH];
  logic [CNT_WIDTH-1:0]  mcycle_q, minstret_q;

  logic [DATA_WIDTH-1:0] operand, old_val, new_val;
  logic [CNT_WIDTH-1:0]  cnt_val, cnt_wr_val;
  logic [IDX_W-1:0]      scratch_idx;
  logic                  hit_scratch, hit_cnt, cnt_sel, cnt_hi, cnt_ro;
  logic                  wr_req, illegal, do_write;

  // 0x340 has zero low bits, so the same slice indexes scratch0 and scratch1..N-1.
  assign scratch_idx = addr_i[IDX_W-1:0];

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    operand     = op_i[2] ? DATA_WIDTH'(uimm_i) : rs1_data_i;
    hit_scratch = 1'b0;
    hit_cnt     = 1'b0;
    cnt_sel     = addr_i[1];
    cnt_hi      = addr_i[7];
    cnt_ro      = (addr_i[11:8] == 4'hC);

    if (addr_i == 12'h340) begin
      hit_scratch = 1'b1;
    end else if (addr_i[11:3] == 9'h0F8 && addr_i[2:0] != 3'd0 &&
                 int'(addr_i[2:0]) < NUM_SCRATCH) begin
      hit_scratch = 1'b1;
    end

    if ((addr_i[11:8] == 4'hB || addr_i[11:8] == 4'hC) &&
        addr_i[6:2] == 5'd0 && addr_i[0] == 1'b0) begin
      hit_cnt = 1'b1;
    end

    // Set/clear with a zero source is a pure read and never counts as a write.
    case (op_i[1:0])
      2'b01:   wr_req = 1'b1;
      2'b10,
      2'b11:   wr_req = op_i[2] ? (uimm_i != 5'd0) : !rs1_zero_i;
      default: wr_req = 1'b0;
    endcase

    cnt_val = cnt_sel ? minstret_q : mcycle_q;
    old_val = '0;
    if (hit_scratch) begin
      old_val = scratch_q[scratch_idx];
    end else if (hit_cnt) begin
      old_val = cnt_hi ? DATA_WIDTH'(cnt_val[CNT_WIDTH-1:32]) : cnt_val[DATA_WIDTH-1:0];
    end

    case (op_i[1:0])
      2'b01:   new_val = operand;
      2'b10:   new_val = old_val | operand;
      default: new_val = old_val & ~operand;
    endcase

    cnt_wr_val = cnt_hi ? {new_val[HI_W-1:0], cnt_val[31:0]}
                        : {cnt_val[CNT_WIDTH-1:32], new_val};

    illegal  = (op_i[1:0] == 2'b00) || !(hit_scratch || hit_cnt) ||
               (hit_cnt && cnt_ro && wr_req);
    do_write = valid_i && !illegal && wr_req;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_o   <= 1'b0;
      illegal_o  <= 1'b0;
      rdata_o    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
      // NOTE: the scratch array is architecturally visible, so it is reset like any other register.
      for (int i = 0; i < SCR_DEPTH; i++) scratch_q[i] <= '0;
    end else begin
      rvalid_o  <= valid_i;
      illegal_o <= valid_i && illegal;
      rdata_o   <= (valid_i && !illegal) ? old_val : '0;

      if (do_write && hit_scratch) scratch_q[scratch_idx] <= new_val;

      // A CSR write to a counter takes priority over that cycle's increment.
      if (do_write && hit_cnt && !cnt_sel) mcycle_q <= cnt_wr_val;
      else                                 mcycle_q <= mcycle_q + CNT_ONE;

      if (do_write && hit_cnt && cnt_sel)  minstret_q <= cnt_wr_val;
      else if (instret_i)                  minstret_q <= minstret_q + CNT_ONE;
    end
  end

endmodule
